// File: rtl/demux_8x32_ctrl_pkg.sv
// Shared types and constants for the 8-to-32 byte-to-word demux controller.
// Byte slices are ordered MSB-first: byte 0 lands in [31:24].
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  localparam int BYTE0_LSB = 24;
  localparam int BYTE1_LSB = 16;
  localparam int BYTE2_LSB = 8;
  localparam int BYTE3_LSB = 0;

  function automatic int byte_lsb(input logic [1:0] idx);
    case (idx)
      2'd0:    return BYTE0_LSB;
      2'd1:    return BYTE1_LSB;
      2'd2:    return BYTE2_LSB;
      default: return BYTE3_LSB;
    endcase
  endfunction

endpackage

// File: rtl/demux_8x32_ctrl_if.sv
// Byte-in / word-lane-out bus of the demux controller.
// master = upstream byte source plus lane status, slave = the controller.
interface demux_8x32_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
);
  import demux_ctrl_pkg::*;

  logic                 valid_in;
  logic [BYTE_W-1:0]    data_in;
  logic [NUM_LANES-1:0] lane_full;
  logic                 ready_out;
  logic [WORD_W-1:0]    data_out;
  logic [NUM_LANES-1:0] lane_wr;
  logic [1:0]           byte_idx;
  logic                 frag_err;
  logic                 ovf_err;
  logic [CNT_W-1:0]     word_count;

  modport master (
    output valid_in, data_in, lane_full,
    input  ready_out, data_out, lane_wr, byte_idx, frag_err, ovf_err, word_count
  );

  modport slave (
    input  valid_in, data_in, lane_full,
    output ready_out, data_out, lane_wr, byte_idx, frag_err, ovf_err, word_count
  );

endinterface

// File: rtl/demux_8x32_ctrl_picker.sv
// Combinational round-robin picker: first available lane at or above the
// pointer, wrapping modulo NUM_LANES.
module rr_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int PTR_W     = $clog2(NUM_LANES)
) (
  input  logic [PTR_W-1:0]     i_ptr,
  input  logic [NUM_LANES-1:0] i_avail,
  output logic                 o_found,
  output logic [PTR_W-1:0]     o_idx
);

  logic [PTR_W:0] w_pos;

  // Walk from the farthest offset down so the nearest free lane wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_pos >= (PTR_W + 1)'(NUM_LANES))
        w_pos = w_pos - (PTR_W + 1)'(NUM_LANES);
      if (i_avail[w_pos[PTR_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/demux_8x32_ctrl.sv
// Byte-to-word assembly and round-robin lane dispatch for the clk_4f domain.
// Holds a completed word (and back-pressures) while every lane is full.
module demux_8x32_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  demux_8x32_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_LANES);

  state_t               r_state,    w_state_nxt;
  logic [1:0]           r_byte_idx, w_idx_nxt;
  logic [WORD_W-1:0]    r_word,     w_word_nxt;
  logic [WORD_W-1:0]    r_data_out, w_dout_nxt;
  logic [NUM_LANES-1:0] r_lane_wr,  w_wr_nxt;
  logic                 r_frag,     w_frag_nxt;
  logic                 r_ovf,      w_ovf_nxt;
  logic [CNT_W-1:0]     r_count,    w_cnt_nxt;
  logic [PTR_W-1:0]     r_ptr,      w_ptr_nxt;

  logic                 w_found;
  logic [PTR_W-1:0]     w_sel;
  logic [NUM_LANES-1:0] w_avail;
  logic                 w_dispatch;
  logic [WORD_W-1:0]    w_disp_word;
  logic [WORD_W-1:0]    w_full_word;

  assign w_avail     = ~bus.lane_full;
  assign w_full_word = {r_word[WORD_W-1:BYTE_W], bus.data_in};

  rr_lane_picker #(.NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_picker (
    .i_ptr   (r_ptr),
    .i_avail (w_avail),
    .o_found (w_found),
    .o_idx   (w_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_byte_idx;
    w_word_nxt  = r_word;
    w_dout_nxt  = r_data_out;
    w_wr_nxt    = '0;
    w_frag_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_cnt_nxt   = r_count;
    w_ptr_nxt   = r_ptr;
    w_dispatch  = 1'b0;
    w_disp_word = r_word;

    unique case (r_state)
      IDLE, FILL: begin
        if (bus.valid_in) begin
          if (r_byte_idx == 2'd3) begin
            w_idx_nxt = 2'd0;
            if (w_found) begin
              w_dispatch  = 1'b1;
              w_disp_word = w_full_word;
            end else begin
              w_word_nxt  = w_full_word;
              w_state_nxt = HOLD;
            end
          end else begin
            w_word_nxt[byte_lsb(r_byte_idx) +: BYTE_W] = bus.data_in;
            w_idx_nxt   = r_byte_idx + 2'd1;
            w_state_nxt = FILL;
          end
        end else if (r_state == FILL) begin
          w_frag_nxt  = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        // A byte arriving here is dropped even if the held word leaves now.
        w_ovf_nxt = bus.valid_in;
        if (w_found) begin
          w_dispatch  = 1'b1;
          w_disp_word = r_word;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_dispatch) begin
      w_dout_nxt        = w_disp_word;
      w_wr_nxt[w_sel]   = 1'b1;
      w_cnt_nxt         = r_count + CNT_W'(1);
      w_ptr_nxt         = (w_sel == PTR_W'(NUM_LANES - 1)) ? '0 : w_sel + PTR_W'(1);
      w_state_nxt       = IDLE;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= IDLE;
      r_byte_idx <= 2'd0;
      r_word     <= '0;
      r_data_out <= '0;
      r_lane_wr  <= '0;
      r_frag     <= 1'b0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_idx_nxt;
      r_word     <= w_word_nxt;
      r_data_out <= w_dout_nxt;
      r_lane_wr  <= w_wr_nxt;
      r_frag     <= w_frag_nxt;
      r_ovf      <= w_ovf_nxt;
      r_count    <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign bus.ready_out  = (r_state != HOLD);
  assign bus.data_out   = r_data_out;
  assign bus.lane_wr    = r_lane_wr;
  assign bus.byte_idx   = r_byte_idx;
  assign bus.frag_err   = r_frag;
  assign bus.ovf_err    = r_ovf;
  assign bus.word_count = r_count;

endmodule

// File: tb/tb_demux_8x32_ctrl.sv
// Directed-vector bench for demux_8x32_ctrl: table of per-cycle stimulus and
// hand-computed outputs, plus an asynchronous mid-word reset sequence.
module tb_demux_8x32_ctrl;
  import demux_ctrl_pkg::*;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b0;

  always #5 clk_4f = ~clk_4f;

  demux_8x32_ctrl_if #(.NUM_LANES(4), .CNT_W(16)) bus ();

  demux_8x32_ctrl #(.NUM_LANES(4), .CNT_W(16)) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  typedef struct {
    bit          rst;
    bit          valid;
    logic [7:0]  data;
    logic [3:0]  lf;
    logic [3:0]  wr;
    logic [31:0] dout;
    bit          rdy;
    logic [1:0]  idx;
    bit          frag;
    bit          ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit v, input logic [7:0] d, input logic [3:0] lf,
                     input logic [3:0] wr, input logic [31:0] dout, input bit rdy,
                     input logic [1:0] idx, input bit fr, input bit ov, input logic [15:0] cnt);
    vec_t e;
    e.rst = rst; e.valid = v; e.data = d; e.lf = lf; e.wr = wr; e.dout = dout;
    e.rdy = rdy; e.idx = idx; e.frag = fr; e.ovf = ov; e.cnt = cnt;
    vecs.push_back(e);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] wr, input logic [31:0] dout,
                         input bit rdy, input logic [1:0] idx, input bit fr, input bit ov,
                         input logic [15:0] cnt);
    chk({tag, " lane_wr"},    32'(bus.lane_wr),    32'(wr));
    chk({tag, " data_out"},   bus.data_out,        dout);
    chk({tag, " ready_out"},  32'(bus.ready_out),  32'(rdy));
    chk({tag, " byte_idx"},   32'(bus.byte_idx),   32'(idx));
    chk({tag, " frag_err"},   32'(bus.frag_err),   32'(fr));
    chk({tag, " ovf_err"},    32'(bus.ovf_err),    32'(ov));
    chk({tag, " word_count"}, 32'(bus.word_count), 32'(cnt));
  endtask

  task automatic send(input bit v, input logic [7:0] d, input logic [3:0] lf);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.lane_full = lf;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.lane_full = 4'h0;
    reset_L       = 1'b0;
    @(posedge clk_4f);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [4];
    logic [3:0]  lanes [4];
    logic [31:0] last;

    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.lane_full = 4'h0;

    // DEADBEEF to lane 0, then an idle cycle
    add(1, 1, 8'hDE, 4'h0, 4'h0, 32'h0,        1, 2'd1, 0, 0, 16'd0);
    add(0, 1, 8'hAD, 4'h0, 4'h0, 32'h0,        1, 2'd2, 0, 0, 16'd0);
    add(0, 1, 8'hBE, 4'h0, 4'h0, 32'h0,        1, 2'd3, 0, 0, 16'd0);
    add(0, 1, 8'hEF, 4'h0, 4'h1, 32'hDEADBEEF, 1, 2'd0, 0, 0, 16'd1);
    add(0, 0, 8'h00, 4'h0, 4'h0, 32'hDEADBEEF, 1, 2'd0, 0, 0, 16'd1);

    // 16 back-to-back bytes from reset: lanes 0,1,2,3 in turn
    words = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    lanes = '{4'h1, 4'h2, 4'h4, 4'h8};
    last  = 32'h0;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 3) begin
        last = words[k / 4];
        add(k == 0, 1, 8'(8'h10 + k), 4'h0, lanes[k / 4], last, 1, 2'((k + 1) % 4), 0, 0, 16'(k / 4 + 1));
      end else begin
        add(k == 0, 1, 8'(8'h10 + k), 4'h0, 4'h0, last, 1, 2'((k + 1) % 4), 0, 0, 16'(k / 4));
      end
    end

    // Pointer to 1, then lane 1 full: lane 2 chosen, pointer to 3, next goes to lane 3
    add(0, 1, 8'h20, 4'h0, 4'h0, 32'h1C1D1E1F, 1, 2'd1, 0, 0, 16'd4);
    add(0, 1, 8'h21, 4'h0, 4'h0, 32'h1C1D1E1F, 1, 2'd2, 0, 0, 16'd4);
    add(0, 1, 8'h22, 4'h0, 4'h0, 32'h1C1D1E1F, 1, 2'd3, 0, 0, 16'd4);
    add(0, 1, 8'h23, 4'h0, 4'h1, 32'h20212223, 1, 2'd0, 0, 0, 16'd5);
    add(0, 1, 8'h30, 4'h2, 4'h0, 32'h20212223, 1, 2'd1, 0, 0, 16'd5);
    add(0, 1, 8'h31, 4'h2, 4'h0, 32'h20212223, 1, 2'd2, 0, 0, 16'd5);
    add(0, 1, 8'h32, 4'h2, 4'h0, 32'h20212223, 1, 2'd3, 0, 0, 16'd5);
    add(0, 1, 8'h33, 4'h2, 4'h4, 32'h30313233, 1, 2'd0, 0, 0, 16'd6);
    add(0, 1, 8'h40, 4'h0, 4'h0, 32'h30313233, 1, 2'd1, 0, 0, 16'd6);
    add(0, 1, 8'h41, 4'h0, 4'h0, 32'h30313233, 1, 2'd2, 0, 0, 16'd6);
    add(0, 1, 8'h42, 4'h0, 4'h0, 32'h30313233, 1, 2'd3, 0, 0, 16'd6);
    add(0, 1, 8'h43, 4'h0, 4'h8, 32'h40414243, 1, 2'd0, 0, 0, 16'd7);

    // All full at byte 3 -> HOLD; overflow byte; release with 1011 -> lane 2
    add(0, 1, 8'hA0, 4'hF, 4'h0, 32'h40414243, 1, 2'd1, 0, 0, 16'd7);
    add(0, 1, 8'hA1, 4'hF, 4'h0, 32'h40414243, 1, 2'd2, 0, 0, 16'd7);
    add(0, 1, 8'hA2, 4'hF, 4'h0, 32'h40414243, 1, 2'd3, 0, 0, 16'd7);
    add(0, 1, 8'hA3, 4'hF, 4'h0, 32'h40414243, 0, 2'd0, 0, 0, 16'd7);
    add(0, 1, 8'h55, 4'hF, 4'h0, 32'h40414243, 0, 2'd0, 0, 1, 16'd7);
    add(0, 0, 8'h00, 4'hF, 4'h0, 32'h40414243, 0, 2'd0, 0, 0, 16'd7);
    add(0, 0, 8'h00, 4'hB, 4'h4, 32'hA0A1A2A3, 1, 2'd0, 0, 0, 16'd8);
    add(0, 0, 8'h00, 4'h0, 4'h0, 32'hA0A1A2A3, 1, 2'd0, 0, 0, 16'd8);

    // HOLD again; overflow byte on the same edge the held word leaves to lane 3
    add(0, 1, 8'hB0, 4'hF, 4'h0, 32'hA0A1A2A3, 1, 2'd1, 0, 0, 16'd8);
    add(0, 1, 8'hB1, 4'hF, 4'h0, 32'hA0A1A2A3, 1, 2'd2, 0, 0, 16'd8);
    add(0, 1, 8'hB2, 4'hF, 4'h0, 32'hA0A1A2A3, 1, 2'd3, 0, 0, 16'd8);
    add(0, 1, 8'hB3, 4'hF, 4'h0, 32'hA0A1A2A3, 0, 2'd0, 0, 0, 16'd8);
    add(0, 1, 8'h66, 4'h7, 4'h8, 32'hB0B1B2B3, 1, 2'd0, 0, 1, 16'd9);
    add(0, 0, 8'h00, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd0, 0, 0, 16'd9);

    // Fragment then a clean word
    add(0, 1, 8'h11, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd1, 0, 0, 16'd9);
    add(0, 1, 8'h22, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd2, 0, 0, 16'd9);
    add(0, 0, 8'h00, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd0, 1, 0, 16'd9);
    add(0, 1, 8'h01, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd1, 0, 0, 16'd9);
    add(0, 1, 8'h02, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd2, 0, 0, 16'd9);
    add(0, 1, 8'h03, 4'h0, 4'h0, 32'hB0B1B2B3, 1, 2'd3, 0, 0, 16'd9);
    add(0, 1, 8'h04, 4'h0, 4'h1, 32'h01020304, 1, 2'd0, 0, 0, 16'd10);

    // Reset state
    @(posedge clk_4f);
    #1;
    chk_all("reset", 4'h0, 32'h0, 1, 2'd0, 0, 0, 16'd0);
    reset_L = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].valid, vecs[i].data, vecs[i].lf);
      chk_all($sformatf("vec%0d", i), vecs[i].wr, vecs[i].dout, vecs[i].rdy,
              vecs[i].idx, vecs[i].frag, vecs[i].ovf, vecs[i].cnt);
    end

    // Asynchronous reset between byte 2 and byte 3
    send(1, 8'h77, 4'h0);
    send(1, 8'h88, 4'h0);
    send(1, 8'h99, 4'h0);
    chk("pre-reset byte_idx", 32'(bus.byte_idx), 32'd3);
    bus.valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("async reset", 4'h0, 32'h0, 1, 2'd0, 0, 0, 16'd0);
    @(posedge clk_4f);
    #1;
    chk_all("in reset", 4'h0, 32'h0, 1, 2'd0, 0, 0, 16'd0);
    reset_L = 1'b1;
    send(1, 8'hC1, 4'h0);
    chk_all("post-reset b0", 4'h0, 32'h0, 1, 2'd1, 0, 0, 16'd0);
    send(1, 8'hC2, 4'h0);
    send(1, 8'hC3, 4'h0);
    send(1, 8'hC4, 4'h0);
    chk_all("post-reset word", 4'h1, 32'hC1C2C3C4, 1, 2'd0, 0, 0, 16'd1);
    send(0, 8'h00, 4'h0);
    chk_all("post-reset idle", 4'h0, 32'hC1C2C3C4, 1, 2'd0, 0, 0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
